// File: rtl/tictactoe_game_ctrl_if.sv
// Button inputs and rendered game state shared between the board buttons,
// the game controller and the VGA driver.
interface tictactoe_game_ctrl_if;
    logic       btn_move;
    logic       btn_place;
    logic       btn_restart;
    logic [1:0] position_1;
    logic [1:0] position_2;
    logic [1:0] position_3;
    logic [1:0] position_4;
    logic [1:0] position_5;
    logic [1:0] position_6;
    logic [1:0] position_7;
    logic [1:0] position_8;
    logic [1:0] position_9;
    logic [3:0] cursor;
    logic [1:0] cur_player;
    logic [1:0] winner;
    logic       draw;
    logic       game_over;
    logic       illegal_place;

    modport master (
        output btn_move, btn_place, btn_restart,
        input  position_1, position_2, position_3, position_4, position_5,
               position_6, position_7, position_8, position_9,
               cursor, cur_player, winner, draw, game_over, illegal_place
    );

    modport slave (
        input  btn_move, btn_place, btn_restart,
        output position_1, position_2, position_3, position_4, position_5,
               position_6, position_7, position_8, position_9,
               cursor, cur_player, winner, draw, game_over, illegal_place
    );
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// Tic-tac-toe controller: debounces three buttons into one-cycle commands and
// runs the PLAY/CHECK/OVER game FSM that owns the registered board.
module tictactoe_game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic                  Clk,
    input logic                  Reset_n,
    tictactoe_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       raw, sync1, sync2, stable, cmd;
    logic [CNT_W-1:0] cnt [3];

    assign raw = {bus.btn_restart, bus.btn_place, bus.btn_move};

    // Counter runs only while the synchronized level disagrees with the
    // accepted level; a pulse is issued only when a rising level is accepted.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            cmd    <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cmd   <= '0;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                    cmd[i]    <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic move_cmd, place_cmd, restart_cmd;
    assign move_cmd    = cmd[0];
    assign place_cmd   = cmd[1];
    assign restart_cmd = cmd[2];

    state_t          state, state_nxt;
    logic [8:0][1:0] board, board_nxt;
    logic [3:0]      cursor, cursor_nxt, idx;
    logic [1:0]      player, player_nxt, winner, winner_nxt, win_code;
    logic            draw, draw_nxt, game_over, game_over_nxt;
    logic            illegal, illegal_nxt, full;

    function automatic logic [1:0] line_code(input logic [1:0] a, b, c);
        if (a != 2'b00 && a == b && a == c) return a;
        return 2'b00;
    endfunction

    always_comb begin
        win_code = 2'b00;
        if (win_code == 2'b00) win_code = line_code(board[0], board[1], board[2]);
        if (win_code == 2'b00) win_code = line_code(board[3], board[4], board[5]);
        if (win_code == 2'b00) win_code = line_code(board[6], board[7], board[8]);
        if (win_code == 2'b00) win_code = line_code(board[0], board[3], board[6]);
        if (win_code == 2'b00) win_code = line_code(board[1], board[4], board[7]);
        if (win_code == 2'b00) win_code = line_code(board[2], board[5], board[8]);
        if (win_code == 2'b00) win_code = line_code(board[0], board[4], board[8]);
        if (win_code == 2'b00) win_code = line_code(board[2], board[4], board[6]);
        full = 1'b1;
        for (int i = 0; i < 9; i++) if (board[i] == 2'b00) full = 1'b0;
    end

    assign idx = cursor - 4'd1;

    // NOTE: every next-value gets its current value first so no path through
    // this block leaves a variable unassigned and infers a latch.
    always_comb begin
        state_nxt   = state;
        board_nxt   = board;
        cursor_nxt  = cursor;
        player_nxt  = player;
        winner_nxt  = winner;
        draw_nxt    = draw;
        illegal_nxt = 1'b0;
        if (restart_cmd) begin
            state_nxt  = PLAY;
            board_nxt  = '0;
            cursor_nxt = 4'd1;
            player_nxt = 2'b01;
            winner_nxt = 2'b00;
            draw_nxt   = 1'b0;
        end else begin
            case (state)
                PLAY: begin
                    if (place_cmd) begin
                        if (board[idx] == 2'b00) begin
                            board_nxt[idx] = player;
                            state_nxt      = CHECK;
                        end else begin
                            illegal_nxt = 1'b1;
                        end
                    end else if (move_cmd) begin
                        cursor_nxt = (cursor == 4'd9) ? 4'd1 : cursor + 4'd1;
                    end
                end
                CHECK: begin
                    if (win_code != 2'b00) begin
                        winner_nxt = win_code;
                        state_nxt  = OVER;
                    end else if (full) begin
                        draw_nxt  = 1'b1;
                        state_nxt = OVER;
                    end else begin
                        player_nxt = (player == 2'b01) ? 2'b10 : 2'b01;
                        state_nxt  = PLAY;
                    end
                end
                OVER:    ;
                default: state_nxt = PLAY;
            endcase
        end
        game_over_nxt = (state_nxt == OVER);
    end

    // NOTE: the board is cleared by reset like any other state register, since
    // a reset mid-game must leave no stale marks for the display.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= PLAY;
            board     <= '0;
            cursor    <= 4'd1;
            player    <= 2'b01;
            winner    <= 2'b00;
            draw      <= 1'b0;
            game_over <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            state     <= state_nxt;
            board     <= board_nxt;
            cursor    <= cursor_nxt;
            player    <= player_nxt;
            winner    <= winner_nxt;
            draw      <= draw_nxt;
            game_over <= game_over_nxt;
            illegal   <= illegal_nxt;
        end
    end

    assign bus.position_1    = board[0];
    assign bus.position_2    = board[1];
    assign bus.position_3    = board[2];
    assign bus.position_4    = board[3];
    assign bus.position_5    = board[4];
    assign bus.position_6    = board[5];
    assign bus.position_7    = board[6];
    assign bus.position_8    = board[7];
    assign bus.position_9    = board[8];
    assign bus.cursor        = cursor;
    assign bus.cur_player    = player;
    assign bus.winner        = winner;
    assign bus.draw          = draw;
    assign bus.game_over     = game_over;
    assign bus.illegal_place = illegal;
endmodule

// File: tb/tb_tictactoe_game_ctrl.sv
// Directed bench for tictactoe_game_ctrl with a 4-cycle debounce; each task
// drives button presses and compares outputs against hand-computed values.
module tb_tictactoe_game_ctrl;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cur = 1;

    always #5 Clk = ~Clk;

    tictactoe_game_ctrl_if bus ();

    tictactoe_game_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    wire [17:0] board_obs = {bus.position_9, bus.position_8, bus.position_7,
                             bus.position_6, bus.position_5, bus.position_4,
                             bus.position_3, bus.position_2, bus.position_1};

    task automatic set_btn(input int which, input logic v);
        case (which)
            0:       bus.btn_move = v;
            1:       bus.btn_place = v;
            default: bus.btn_restart = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) @(negedge Clk);
        set_btn(which, 1'b0);
        repeat (12) @(negedge Clk);
    endtask

    task automatic goto_cell(input int n);
        for (int k = 0; k < 9 && exp_cur != n; k++) begin
            press(0, 12);
            exp_cur = (exp_cur == 9) ? 1 : exp_cur + 1;
        end
    endtask

    task automatic place_at(input int n);
        goto_cell(n);
        press(1, 12);
    endtask

    task automatic do_restart();
        press(2, 12);
        exp_cur = 1;
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (board_obs !== 18'd0 || bus.cursor !== 4'd1 || bus.cur_player !== 2'b01 ||
            bus.winner !== 2'b00 || bus.draw !== 1'b0 || bus.game_over !== 1'b0 ||
            bus.illegal_place !== 1'b0) begin
            failures++;
            $display("FAIL %s: board=%h cursor=%0d player=%b winner=%b draw=%b over=%b illegal=%b, required all cleared, cursor=1 player=01",
                     name, board_obs, bus.cursor, bus.cur_player, bus.winner, bus.draw,
                     bus.game_over, bus.illegal_place);
        end
    endtask

    task automatic test_reset();
        bus.btn_move = 1'b0;
        bus.btn_place = 1'b0;
        bus.btn_restart = 1'b0;
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_cleared("reset_asserted");
        Reset_n = 1'b1;
        repeat (100) @(negedge Clk);
        check_cleared("reset_idle_100");
        exp_cur = 1;
    endtask

    task automatic test_move();
        set_btn(0, 1'b1);
        repeat (2) @(negedge Clk);
        set_btn(0, 1'b0);
        repeat (20) @(negedge Clk);
        checks++;
        if (bus.cursor !== 4'd1) begin
            failures++;
            $display("FAIL glitch_move: cursor=%0d required 1", bus.cursor);
        end
        press(0, 20);
        checks++;
        if (bus.cursor !== 4'd2) begin
            failures++;
            $display("FAIL held_move: cursor=%0d required 2", bus.cursor);
        end
        repeat (7) press(0, 12);
        checks++;
        if (bus.cursor !== 4'd9) begin
            failures++;
            $display("FAIL move_to_9: cursor=%0d required 9", bus.cursor);
        end
        press(0, 12);
        checks++;
        if (bus.cursor !== 4'd1) begin
            failures++;
            $display("FAIL move_wrap: cursor=%0d required 1", bus.cursor);
        end
        press(0, 12);
        checks++;
        if (bus.cursor !== 4'd2) begin
            failures++;
            $display("FAIL move_after_wrap: cursor=%0d required 2", bus.cursor);
        end
        exp_cur = 2;
    endtask

    task automatic test_win();
        int t_pos = -1;
        int t_over = -1;
        do_restart();
        place_at(1);
        checks++;
        if (bus.position_1 !== 2'b01 || bus.cur_player !== 2'b10) begin
            failures++;
            $display("FAIL first_place: pos1=%b player=%b required 01/10", bus.position_1, bus.cur_player);
        end
        place_at(4);
        place_at(2);
        place_at(5);
        goto_cell(3);
        set_btn(1, 1'b1);
        for (int i = 1; i <= 24; i++) begin
            @(negedge Clk);
            if (t_pos < 0 && bus.position_3 === 2'b01) t_pos = i;
            if (t_over < 0 && bus.game_over === 1'b1) t_over = i;
            if (i == 12) set_btn(1, 1'b0);
        end
        checks++;
        if (t_pos != 7 || t_over != 8) begin
            failures++;
            $display("FAIL win_timing: cell written at cycle %0d, game_over at cycle %0d, required 7 and 8", t_pos, t_over);
        end
        checks++;
        if (board_obs !== {2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01}) begin
            failures++;
            $display("FAIL win_board: board=%h required 00295", board_obs);
        end
        checks++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1 || bus.draw !== 1'b0 || bus.cur_player !== 2'b01) begin
            failures++;
            $display("FAIL win_flags: winner=%b over=%b draw=%b player=%b required 01/1/0/01",
                     bus.winner, bus.game_over, bus.draw, bus.cur_player);
        end
    endtask

    task automatic test_illegal();
        int hi = 0;
        do_restart();
        place_at(5);
        checks++;
        if (bus.position_5 !== 2'b01 || bus.cur_player !== 2'b10) begin
            failures++;
            $display("FAIL place_5: pos5=%b player=%b required 01/10", bus.position_5, bus.cur_player);
        end
        set_btn(1, 1'b1);
        for (int i = 1; i <= 24; i++) begin
            @(negedge Clk);
            if (bus.illegal_place === 1'b1) hi++;
            if (i == 12) set_btn(1, 1'b0);
        end
        checks++;
        if (hi != 1) begin
            failures++;
            $display("FAIL illegal_pulse: illegal_place high %0d cycles required 1", hi);
        end
        checks++;
        if (board_obs !== {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00} ||
            bus.cur_player !== 2'b10 || bus.game_over !== 1'b0) begin
            failures++;
            $display("FAIL illegal_state: board=%h player=%b over=%b required 00100/10/0",
                     board_obs, bus.cur_player, bus.game_over);
        end
    endtask

    task automatic test_draw();
        do_restart();
        place_at(1);
        place_at(2);
        place_at(3);
        place_at(5);
        place_at(4);
        place_at(6);
        place_at(8);
        place_at(7);
        place_at(9);
        checks++;
        if (board_obs !== {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01}) begin
            failures++;
            $display("FAIL draw_board: board=%h required 15a59", board_obs);
        end
        checks++;
        if (bus.draw !== 1'b1 || bus.winner !== 2'b00 || bus.game_over !== 1'b1 || bus.cur_player !== 2'b01) begin
            failures++;
            $display("FAIL draw_flags: draw=%b winner=%b over=%b player=%b required 1/00/1/01",
                     bus.draw, bus.winner, bus.game_over, bus.cur_player);
        end
        press(0, 12);
        press(1, 12);
        checks++;
        if (bus.cursor !== 4'd9 || board_obs !== {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01} ||
            bus.draw !== 1'b1 || bus.game_over !== 1'b1 || bus.illegal_place !== 1'b0) begin
            failures++;
            $display("FAIL over_ignores: cursor=%0d board=%h draw=%b over=%b required 9/15a59/1/1",
                     bus.cursor, board_obs, bus.draw, bus.game_over);
        end
    endtask

    task automatic test_restart();
        do_restart();
        check_cleared("restart_in_over");
        place_at(1);
        goto_cell(2);
        checks++;
        if (bus.position_1 !== 2'b01 || bus.cursor !== 4'd2 || bus.cur_player !== 2'b10) begin
            failures++;
            $display("FAIL pre_restart: pos1=%b cursor=%0d player=%b required 01/2/10",
                     bus.position_1, bus.cursor, bus.cur_player);
        end
        set_btn(1, 1'b1);
        set_btn(2, 1'b1);
        repeat (12) @(negedge Clk);
        set_btn(1, 1'b0);
        set_btn(2, 1'b0);
        repeat (12) @(negedge Clk);
        exp_cur = 1;
        check_cleared("restart_with_place");
        place_at(1);
        goto_cell(3);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check_cleared("async_reset_mid_game");
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cur = 1;
        repeat (5) @(negedge Clk);
        check_cleared("after_reset_release");
    endtask

    initial begin
        test_reset();
        test_move();
        test_win();
        test_illegal();
        test_draw();
        test_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
